// File: rtl/n64adv_vpll_seq_if.sv
// n64adv_vpll_seq_if: controller/PLL side bundle of the VCLK/VPLL
// Tx clock switch-over sequencer.
interface n64adv_vpll_seq_if;
   logic       USE_VPLL;
   logic       PLL_LOCKED_i;
   logic       PLL_ARESET;
   logic [1:0] VCLK_Tx_select;
   logic       TxRST_req;
   logic       VPLL_ACTIVE;
   logic       VPLL_ERR;
   logic [2:0] SEQ_STATE;

   modport master (
      output USE_VPLL,
      output PLL_LOCKED_i,
      input  PLL_ARESET,
      input  VCLK_Tx_select,
      input  TxRST_req,
      input  VPLL_ACTIVE,
      input  VPLL_ERR,
      input  SEQ_STATE
   );

   modport slave (
      input  USE_VPLL,
      input  PLL_LOCKED_i,
      output PLL_ARESET,
      output VCLK_Tx_select,
      output TxRST_req,
      output VPLL_ACTIVE,
      output VPLL_ERR,
      output SEQ_STATE
   );
endinterface

// File: rtl/n64adv_vpll_seq.sv
// n64adv_vpll_seq: VCLK <-> video PLL Tx clock switch-over sequencer.
// Define N64ADV_VPLL_RETRY_EN to retry automatically out of FAIL.
module n64adv_vpll_seq #(
   parameter int RST_CYC     = 16,
   parameter int SETTLE_CYC  = 256,
   parameter int GAP_CYC     = 8,
   parameter int TIMEOUT_CYC = 1048576,
   parameter int RETRY_CYC   = 65536
) (
   input logic SYS_CLK,
   input logic SRST,
   n64adv_vpll_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_DIRECT  = 3'd0,
      S_PLL_RST = 3'd1,
      S_WAIT    = 3'd2,
      S_GAP_IN  = 3'd3,
      S_RUN     = 3'd4,
      S_GAP_OUT = 3'd5,
      S_FAIL    = 3'd6
   } state_t;

   localparam int RW = $clog2(RST_CYC + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
   localparam logic [RW-1:0] RST_TOP  = RW'(RST_CYC);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [SW-1:0] SET_TOP  = SW'(SETTLE_CYC);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [GW-1:0] GAP_TOP  = GW'(GAP_CYC);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_TOP   = TW'(TIMEOUT_CYC);

   generate
      if (RST_CYC < 1 || SETTLE_CYC < 1 || GAP_CYC < 1 ||
          TIMEOUT_CYC < 1 || RETRY_CYC < 1) begin : g_bad_param
         $error("n64adv_vpll_seq: cycle parameters must be >= 1");
      end
   endgenerate

   state_t        st;
   state_t        nxt;
   logic [1:0]    sync;
   logic          lock_s;
   logic [RW-1:0] rst_cnt;
   logic [SW-1:0] set_cnt;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          mark;
   logic          fail_set;
   logic [1:0]    sel;
   logic          areset;
   logic          txrst;
   logic          active;
   logic          err;
   logic [1:0]    sel_n;
   logic          areset_n;
   logic          txrst_n;
   logic          active_n;
   logic          err_n;

`ifdef N64ADV_VPLL_RETRY_EN
   localparam int YW = $clog2(RETRY_CYC + 1);
   localparam logic [YW-1:0] RTY_LAST = YW'(RETRY_CYC - 1);
   localparam logic [YW-1:0] RTY_TOP  = YW'(RETRY_CYC);
   logic [YW-1:0] rty_cnt;
`endif

   assign lock_s = sync[1];

   // A dropped request always wins over timeout, settle or lock loss.
   always_comb begin
      nxt      = st;
      fail_set = 1'b0;
      unique case (st)
         S_DIRECT:
            if (bus.USE_VPLL) nxt = S_PLL_RST;
         S_PLL_RST:
            if (!bus.USE_VPLL) nxt = S_DIRECT;
            else if (rst_cnt == RST_LAST) nxt = S_WAIT;
         S_WAIT:
            if (!bus.USE_VPLL) nxt = S_DIRECT;
            else if (lock_s && set_cnt == SET_LAST) nxt = S_GAP_IN;
            else if (to_cnt == TO_LAST) nxt = S_FAIL;
         S_GAP_IN:
            if (gap_cnt == GAP_LAST) nxt = S_RUN;
         S_RUN:
            if (!bus.USE_VPLL) nxt = S_GAP_OUT;
            else if (!lock_s) begin
               nxt      = S_GAP_OUT;
               fail_set = 1'b1;
            end
         S_GAP_OUT:
            if (gap_cnt == GAP_LAST) nxt = mark ? S_FAIL : S_DIRECT;
         S_FAIL:
            if (!bus.USE_VPLL) nxt = S_DIRECT;
`ifdef N64ADV_VPLL_RETRY_EN
            else if (rty_cnt == RTY_LAST) nxt = S_PLL_RST;
`endif
         default:
            nxt = S_DIRECT;
      endcase
   end

   always_comb begin
      sel_n    = 2'b00;
      areset_n = 1'b0;
      txrst_n  = 1'b0;
      active_n = 1'b0;
      unique case (1'b1)
         (nxt == S_GAP_IN): begin
            sel_n   = 2'b10;
            txrst_n = 1'b1;
         end
         (nxt == S_GAP_OUT): begin
            sel_n    = 2'b10;
            txrst_n  = 1'b1;
            areset_n = 1'b1;
         end
         (nxt == S_RUN): begin
            sel_n    = 2'b01;
            active_n = 1'b1;
         end
         (nxt == S_DIRECT || nxt == S_PLL_RST || nxt == S_FAIL):
            areset_n = 1'b1;
         default: ;
      endcase
      err_n = (nxt == S_FAIL) |
              (err & (nxt != S_DIRECT) & (nxt != S_RUN));
   end

   always_ff @(posedge SYS_CLK) begin
      if (SRST) begin
         st      <= S_DIRECT;
         sync    <= 2'b00;
         rst_cnt <= '0;
         set_cnt <= '0;
         gap_cnt <= '0;
         to_cnt  <= '0;
         mark    <= 1'b0;
         sel     <= 2'b00;
         areset  <= 1'b1;
         txrst   <= 1'b0;
         active  <= 1'b0;
         err     <= 1'b0;
`ifdef N64ADV_VPLL_RETRY_EN
         rty_cnt <= '0;
`endif
      end else begin
         sync   <= {sync[0], bus.PLL_LOCKED_i};
         st     <= nxt;
         sel    <= sel_n;
         areset <= areset_n;
         txrst  <= txrst_n;
         active <= active_n;
         err    <= err_n;
         if (nxt != st) begin
            rst_cnt <= '0;
            set_cnt <= '0;
            gap_cnt <= '0;
            to_cnt  <= '0;
            mark    <= fail_set;
`ifdef N64ADV_VPLL_RETRY_EN
            rty_cnt <= '0;
`endif
         end else begin
            unique case (st)
               S_PLL_RST:
                  if (rst_cnt != RST_TOP) rst_cnt <= rst_cnt + 1'b1;
               S_WAIT: begin
                  if (!lock_s) set_cnt <= '0;
                  else if (set_cnt != SET_TOP) set_cnt <= set_cnt + 1'b1;
                  if (to_cnt != TO_TOP) to_cnt <= to_cnt + 1'b1;
               end
               S_GAP_IN, S_GAP_OUT:
                  if (gap_cnt != GAP_TOP) gap_cnt <= gap_cnt + 1'b1;
`ifdef N64ADV_VPLL_RETRY_EN
               S_FAIL:
                  if (rty_cnt != RTY_TOP) rty_cnt <= rty_cnt + 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.PLL_ARESET     = areset;
   assign bus.VCLK_Tx_select = sel;
   assign bus.TxRST_req      = txrst;
   assign bus.VPLL_ACTIVE    = active;
   assign bus.VPLL_ERR       = err;
   assign bus.SEQ_STATE      = st;

endmodule

// File: tb/tb_n64adv_vpll_seq.sv
// tb_n64adv_vpll_seq: directed plan scenarios plus random traffic
// against a cycle-level reference of the sequencer rules.
module tb_n64adv_vpll_seq;

   localparam int RST_CYC     = 4;
   localparam int SETTLE_CYC  = 8;
   localparam int GAP_CYC     = 4;
   localparam int TIMEOUT_CYC = 64;
   localparam int RETRY_CYC   = 16;

   localparam int P_DIRECT = 0;
   localparam int P_RST    = 1;
   localparam int P_WAIT   = 2;
   localparam int P_GAPIN  = 3;
   localparam int P_RUN    = 4;
   localparam int P_GAPOUT = 5;
   localparam int P_FAIL   = 6;

   logic clk = 1'b0;
   logic srst;
   int   n_checks = 0;
   int   n_err = 0;

   n64adv_vpll_seq_if vif ();

   n64adv_vpll_seq #(
      .RST_CYC(RST_CYC),
      .SETTLE_CYC(SETTLE_CYC),
      .GAP_CYC(GAP_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .RETRY_CYC(RETRY_CYC)
   ) dut (
      .SYS_CLK(clk),
      .SRST(srst),
      .bus(vif)
   );

   always #5 clk = ~clk;

   int   m_ph;
   int   m_t;
   int   m_run;
   bit   m_lost;
   bit   m_err;
   bit   h0;
   bit   h1;
   logic [1:0] prev_sel;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ls;
      int np;
      if (srst) begin
         m_ph = P_DIRECT; m_t = 0; m_run = 0;
         m_lost = 0; m_err = 0; h0 = 0; h1 = 0;
      end else begin
         ls = h0;
         h0 = h1;
         h1 = vif.PLL_LOCKED_i;
         np = m_ph;
         if (m_ph == P_WAIT) m_run = ls ? m_run + 1 : 0;
         case (m_ph)
            P_DIRECT: if (vif.USE_VPLL) np = P_RST;
            P_RST:
               if (!vif.USE_VPLL) np = P_DIRECT;
               else if (m_t + 1 >= RST_CYC) np = P_WAIT;
            P_WAIT:
               if (!vif.USE_VPLL) np = P_DIRECT;
               else if (m_run >= SETTLE_CYC) np = P_GAPIN;
               else if (m_t + 1 >= TIMEOUT_CYC) np = P_FAIL;
            P_GAPIN: if (m_t + 1 >= GAP_CYC) np = P_RUN;
            P_RUN:
               if (!vif.USE_VPLL) np = P_GAPOUT;
               else if (!ls) begin
                  np = P_GAPOUT;
                  m_lost = 1;
               end
            P_GAPOUT:
               if (m_t + 1 >= GAP_CYC) np = m_lost ? P_FAIL : P_DIRECT;
            P_FAIL:
               if (!vif.USE_VPLL) np = P_DIRECT;
`ifdef N64ADV_VPLL_RETRY_EN
               else if (m_t + 1 >= RETRY_CYC) np = P_RST;
`endif
            default: np = P_DIRECT;
         endcase
         if (np != m_ph) begin
            m_t = 0;
            m_run = 0;
            if (np != P_GAPOUT) m_lost = 0;
         end else begin
            m_t++;
         end
         if (np == P_FAIL) m_err = 1;
         else if (np == P_DIRECT || np == P_RUN) m_err = 0;
         m_ph = np;
      end
   endtask

   function automatic logic [8:0] model_out();
      logic [1:0] s;
      logic a, t, v;
      s = (m_ph == P_GAPIN || m_ph == P_GAPOUT) ? 2'b10 :
          (m_ph == P_RUN) ? 2'b01 : 2'b00;
      a = (m_ph == P_DIRECT || m_ph == P_RST ||
           m_ph == P_GAPOUT || m_ph == P_FAIL);
      t = (m_ph == P_GAPIN || m_ph == P_GAPOUT);
      v = (m_ph == P_RUN);
      return {3'(m_ph), s, a, t, v, m_err};
   endfunction

   function automatic logic [8:0] dut_out();
      return {vif.SEQ_STATE, vif.VCLK_Tx_select, vif.PLL_ARESET,
              vif.TxRST_req, vif.VPLL_ACTIVE, vif.VPLL_ERR};
   endfunction

   task automatic step();
      bit was_rst;
      bit legal;
      @(posedge clk);
      was_rst = srst;
      model_step();
      #1;
      chk("outputs", dut_out(), model_out());
      legal = was_rst ||
              !((prev_sel == 2'b00 && vif.VCLK_Tx_select == 2'b01) ||
                (prev_sel == 2'b01 && vif.VCLK_Tx_select == 2'b00));
      chk("sel_step", legal, 1);
      prev_sel = vif.VCLK_Tx_select;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int n;
      int hi;
      int g;
      int nz;
      bit good;
      bit use_r;

      srst = 1'b1;
      vif.USE_VPLL = 1'b0;
      vif.PLL_LOCKED_i = 1'b0;
      prev_sel = 2'b00;
      steps(2);
      chk("rst_vec", dut_out(), {3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
      srst = 1'b0;
      steps(3);

      // clean switch
      vif.USE_VPLL = 1'b1;
      n = 0; hi = 0;
      while (vif.PLL_ARESET && n < 50) begin
         step(); n++;
         if (vif.PLL_ARESET) hi++;
      end
      chk("areset_hi", hi, RST_CYC);
      vif.PLL_LOCKED_i = 1'b1;
      g = 0;
      while (!vif.VPLL_ACTIVE && n < 100) begin
         step(); n++;
         if (vif.VCLK_Tx_select == 2'b10) g++;
      end
      chk("clean_lat", n, 19);
      chk("gap_len", g, GAP_CYC);
      chk("run_sel", vif.VCLK_Tx_select, 2'b01);

      // request drop in RUN_PLL
      vif.USE_VPLL = 1'b0;
      step();
      chk("drop_sel", vif.VCLK_Tx_select, 2'b10);
      chk("drop_txrst", vif.TxRST_req, 1);
      steps(GAP_CYC + 2);
      chk("drop_state", vif.SEQ_STATE, P_DIRECT);

      // glitchy lock
      vif.PLL_LOCKED_i = 1'b0;
      steps(3);
      vif.USE_VPLL = 1'b1;
      n = 0;
      while (vif.PLL_ARESET && n < 50) begin step(); n++; end
      nz = 0;
      vif.PLL_LOCKED_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (vif.VCLK_Tx_select != 2'b00) nz++;
      end
      vif.PLL_LOCKED_i = 1'b0;
      step();
      if (vif.VCLK_Tx_select != 2'b00) nz++;
      vif.PLL_LOCKED_i = 1'b1;
      n = 0;
      while (vif.VCLK_Tx_select == 2'b00 && n < 60) begin step(); n++; end
      chk("glitch_sel", nz, 0);
      chk("settle_restart", n, 10);
      vif.USE_VPLL = 1'b0;
      steps(GAP_CYC + 6);
      vif.PLL_LOCKED_i = 1'b0;
      steps(3);

      // timeout
      vif.USE_VPLL = 1'b1;
      n = 0;
      while (vif.PLL_ARESET && n < 50) begin step(); n++; end
      n = 0;
      while (vif.SEQ_STATE != P_FAIL && n < 200) begin step(); n++; end
      chk("timeout_len", n, TIMEOUT_CYC);
      chk("fail_err", vif.VPLL_ERR, 1);
      chk("fail_areset", vif.PLL_ARESET, 1);
      chk("fail_sel", vif.VCLK_Tx_select, 2'b00);
`ifdef N64ADV_VPLL_RETRY_EN
      n = 0;
      while (vif.SEQ_STATE != P_RST && n < 100) begin step(); n++; end
      chk("retry_len", n, RETRY_CYC);
      chk("retry_err", vif.VPLL_ERR, 1);
`else
      steps(40);
      chk("fail_hold", vif.SEQ_STATE, P_FAIL);
`endif
      vif.USE_VPLL = 1'b0;
      step();
      chk("clr_state", vif.SEQ_STATE, P_DIRECT);
      chk("clr_err", vif.VPLL_ERR, 0);
      steps(2);

      // lock loss in RUN_PLL
      vif.PLL_LOCKED_i = 1'b1;
      vif.USE_VPLL = 1'b1;
      n = 0;
      while (!vif.VPLL_ACTIVE && n < 100) begin step(); n++; end
      chk("loss_run", vif.VPLL_ACTIVE, 1);
      vif.PLL_LOCKED_i = 1'b0;
      n = 0;
      while (vif.VCLK_Tx_select != 2'b10 && n < 20) begin step(); n++; end
      chk("loss_lat", n, 3);
      n = 0;
      while (vif.SEQ_STATE != P_FAIL && n < 20) begin step(); n++; end
      chk("gapout_len", n, GAP_CYC);
      chk("loss_err", vif.VPLL_ERR, 1);
      vif.USE_VPLL = 1'b0;
      step();
      chk("loss_clr", {vif.SEQ_STATE, vif.VPLL_ERR}, {3'd0, 1'b0});
      steps(2);

      // abort mid WAIT_LOCK
      vif.USE_VPLL = 1'b1;
      nz = 0;
      for (int i = 0; i < RST_CYC + 6; i++) begin
         step();
         if (vif.VCLK_Tx_select != 2'b00) nz++;
      end
      chk("abort_in_wait", vif.SEQ_STATE, P_WAIT);
      vif.USE_VPLL = 1'b0;
      step();
      if (vif.VCLK_Tx_select != 2'b00) nz++;
      chk("abort_state", vif.SEQ_STATE, P_DIRECT);
      chk("abort_sel", nz, 0);
      steps(2);

      // SRST during GAP_IN
      vif.PLL_LOCKED_i = 1'b1;
      vif.USE_VPLL = 1'b1;
      n = 0;
      while (vif.VCLK_Tx_select != 2'b10 && n < 100) begin step(); n++; end
      chk("gapin_reach", vif.SEQ_STATE, P_GAPIN);
      srst = 1'b1;
      step();
      chk("gap_srst", dut_out(), {3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
      srst = 1'b0;
      vif.USE_VPLL = 1'b0;
      steps(3);

      // random traffic
      good = 1'b1;
      use_r = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            use_r = !use_r;
            if (use_r) good = ($urandom_range(0, 2) != 0);
         end
         vif.USE_VPLL = use_r;
         if (vif.PLL_ARESET)
            vif.PLL_LOCKED_i = ($urandom_range(0, 19) == 0);
         else if (good)
            vif.PLL_LOCKED_i = ($urandom_range(0, 79) != 0);
         else
            vif.PLL_LOCKED_i = ($urandom_range(0, 9) == 0);
         srst = ($urandom_range(0, 499) == 0);
         step();
      end
      srst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
